muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Iterative integer multiply/divide unit. An operation is accepted in IDLE,
// WIDTH radix-2 steps run in CALC (shift-add for multiply, restoring
// shift-subtract for divide), and SIGN applies the sign fix-up. It also loads
// hi/lo and raises done for one cycle.
//
// Parameters
//   WIDTH  operand width in bits, 4..64 (default 32)
//
// Ports
//   clk    rising-edge clock
//   reset  synchronous, active-low reset
//   start  operation request, sampled only in IDLE
//   op     00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a      multiplicand / dividend
//   b      multiplier / divisor
//   busy   high while in CALC or SIGN
//   done   one-cycle completion pulse
//   hi     product upper half / remainder
//   lo     product lower half / quotient
//   dz     divide-by-zero flag (only when MULDIV_DIVZERO_EN is defined)
//
// Build option
//   MULDIV_DIVZERO_EN  adds the registered dz output
// -----------------------------------------------------------------------------
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
`ifdef MULDIV_DIVZERO_EN
   ,
   output logic             dz
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_SIGN = 2'b10
   } state_t;

   localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0]   ONES_W   = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0]   CNT_LAST = WIDTH'(WIDTH - 1);

   // FSM and control
   state_t           state_r;
   state_t           state_nx_s;
   logic             accept_s;
   logic             busy_r;
   logic             done_r;
   logic [WIDTH-1:0] cnt_r;

   // latched operation
   logic [1:0]       op_r;
   logic             neg_a_r;
   logic             neg_b_r;
   logic             divz_r;

   // working registers: work_hi_r is the accumulator / partial remainder,
   // work_lo_r the multiplier / dividend that turns into product low / quotient,
   // mcand_r the multiplicand / divisor magnitude
   logic [WIDTH-1:0] work_hi_r;
   logic [WIDTH-1:0] work_lo_r;
   logic [WIDTH-1:0] mcand_r;

   // operand magnitudes at acceptance
   logic [WIDTH-1:0] abs_a_s;
   logic [WIDTH-1:0] abs_b_s;

   // single iteration
   logic [WIDTH:0]   mul_sum_s;
   logic [WIDTH:0]   div_shift_s;
   logic             div_ge_s;
   logic [WIDTH-1:0] div_diff_s;
   logic [WIDTH-1:0] step_hi_s;
   logic [WIDTH-1:0] step_lo_s;

   // sign-corrected result
   logic [2*WIDTH-1:0] prod_mag_s;
   logic [2*WIDTH-1:0] prod_res_s;
   logic [WIDTH-1:0]   quo_s;
   logic [WIDTH-1:0]   rem_s;
   logic [WIDTH-1:0]   res_hi_s;
   logic [WIDTH-1:0]   res_lo_s;

   // result registers
   logic [WIDTH-1:0] hi_r;
   logic [WIDTH-1:0] lo_r;

   // Next-state decode: start is only looked at in IDLE, so requests while busy are dropped
   always_comb begin
      state_nx_s = state_r;
      accept_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_nx_s = ST_CALC;
               accept_s   = 1'b1;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_CALC: begin
            if (cnt_r == CNT_LAST) begin
               state_nx_s = ST_SIGN;
            end else begin
               state_nx_s = ST_CALC;
            end
         end
         ST_SIGN: begin
            state_nx_s = ST_IDLE;
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // State register with busy/done registered alongside it
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         busy_r  <= (state_nx_s == ST_CALC) || (state_nx_s == ST_SIGN);
         done_r  <= (state_r == ST_SIGN);
      end
   end

   // Operand magnitudes; only the signed ops (op[0]=1) take the absolute value
   always_comb begin
      if (op[0] && a[WIDTH-1]) begin
         abs_a_s = ~a + ONE_W;
      end else begin
         abs_a_s = a;
      end
      if (op[0] && b[WIDTH-1]) begin
         abs_b_s = ~b + ONE_W;
      end else begin
         abs_b_s = b;
      end
   end

   // One radix-2 step for multiply (shift-add) or divide (restoring shift-subtract)
   always_comb begin
      mul_sum_s   = {1'b0, work_hi_r} + {1'b0, (work_lo_r[0] ? mcand_r : ZERO_W)};
      div_shift_s = {work_hi_r, work_lo_r[WIDTH-1]};
      div_ge_s    = (div_shift_s >= {1'b0, mcand_r});
      // when the trial succeeds the true difference is below the divisor,
      // so dropping the top bit loses nothing
      div_diff_s  = div_shift_s[WIDTH-1:0] - mcand_r;
      if (op_r[1]) begin
         if (div_ge_s) begin
            step_hi_s = div_diff_s;
            step_lo_s = {work_lo_r[WIDTH-2:0], 1'b1};
         end else begin
            step_hi_s = div_shift_s[WIDTH-1:0];
            step_lo_s = {work_lo_r[WIDTH-2:0], 1'b0};
         end
      end else begin
         step_hi_s = mul_sum_s[WIDTH:1];
         step_lo_s = {mul_sum_s[0], work_lo_r[WIDTH-1:1]};
      end
   end

   // Iteration counter: cleared on acceptance, counts 0..WIDTH-1 through CALC
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_r <= ZERO_W;
      end else if (accept_s) begin
         cnt_r <= ZERO_W;
      end else if (state_r == ST_CALC) begin
         cnt_r <= cnt_r + ONE_W;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Operation latch and working registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         op_r      <= 2'b00;
         neg_a_r   <= 1'b0;
         neg_b_r   <= 1'b0;
         divz_r    <= 1'b0;
         work_hi_r <= ZERO_W;
         work_lo_r <= ZERO_W;
         mcand_r   <= ZERO_W;
      end else if (accept_s) begin
         op_r      <= op;
         neg_a_r   <= op[0] & a[WIDTH-1];
         neg_b_r   <= op[0] & b[WIDTH-1];
         divz_r    <= op[1] & (b == ZERO_W);
         work_hi_r <= ZERO_W;
         if (op[1]) begin
            work_lo_r <= abs_a_s;
            mcand_r   <= abs_b_s;
         end else begin
            work_lo_r <= abs_b_s;
            mcand_r   <= abs_a_s;
         end
      end else if (state_r == ST_CALC) begin
         work_hi_r <= step_hi_s;
         work_lo_r <= step_lo_s;
      end else begin
         work_hi_r <= work_hi_r;
         work_lo_r <= work_lo_r;
      end
   end

   // Sign fix-up of the magnitude result
   always_comb begin
      prod_mag_s = {work_hi_r, work_lo_r};
      if (neg_a_r ^ neg_b_r) begin
         prod_res_s = ~prod_mag_s + ONE_2W;
      end else begin
         prod_res_s = prod_mag_s;
      end
      // a zero divisor makes every trial subtraction succeed, leaving
      // quotient all ones and remainder |a|; the quotient is forced so a
      // negative dividend does not flip it, and the remainder fix-up below
      // turns |a| back into a
      if (divz_r) begin
         quo_s = ONES_W;
      end else if (neg_a_r ^ neg_b_r) begin
         quo_s = ~work_lo_r + ONE_W;
      end else begin
         quo_s = work_lo_r;
      end
      // remainder follows the sign of the dividend
      if (neg_a_r) begin
         rem_s = ~work_hi_r + ONE_W;
      end else begin
         rem_s = work_hi_r;
      end
      if (op_r[1]) begin
         res_hi_s = rem_s;
         res_lo_s = quo_s;
      end else begin
         res_hi_s = prod_res_s[2*WIDTH-1:WIDTH];
         res_lo_s = prod_res_s[WIDTH-1:0];
      end
   end

   // Result registers: written only on the SIGN edge, held otherwise
   always_ff @(posedge clk) begin
      if (!reset) begin
         hi_r <= ZERO_W;
         lo_r <= ZERO_W;
      end else if (state_r == ST_SIGN) begin
         hi_r <= res_hi_s;
         lo_r <= res_lo_s;
      end else begin
         hi_r <= hi_r;
         lo_r <= lo_r;
      end
   end

`ifdef MULDIV_DIVZERO_EN
   logic dz_r;

   // Divide-by-zero flag, refreshed with each completion and held between them
   always_ff @(posedge clk) begin
      if (!reset) begin
         dz_r <= 1'b0;
      end else if (state_r == ST_SIGN) begin
         dz_r <= divz_r;
      end else begin
         dz_r <= dz_r;
      end
   end

   assign dz = dz_r;
`endif

   assign busy = busy_r;
   assign done = done_r;
   assign hi   = hi_r;
   assign lo   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//
// Self-checking bench for muldiv_unit at WIDTH=32. Directed cases cover the
// reset state, signed/unsigned products and quotients, signed overflow, divide
// by zero, ignored mid-operation start, back-to-back start in the done cycle
// and abort by reset; a randomized run follows. Expected values come from a
// plain 64-bit arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;
`ifdef MULDIV_DIVZERO_EN
   logic         dz;
`endif

   int vectors     = 0;
   int miscompares = 0;

   logic [W-1:0] prev_hi;
   logic [W-1:0] prev_lo;

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
`ifdef MULDIV_DIVZERO_EN
      ,
      .dz    (dz)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: results straight from integer arithmetic
   function automatic void model(input logic [1:0] mop, input logic [W-1:0] ma,
                                 input logic [W-1:0] mb, output logic [W-1:0] ehi,
                                 output logic [W-1:0] elo, output logic edz);
      longint      sa;
      longint      sb;
      logic [63:0] p;
      sa  = longint'($signed(ma));
      sb  = longint'($signed(mb));
      edz = 1'b0;
      case (mop)
         2'b00: begin
            p   = {32'd0, ma} * {32'd0, mb};
            ehi = p[63:32];
            elo = p[31:0];
         end
         2'b01: begin
            p   = 64'(sa * sb);
            ehi = p[63:32];
            elo = p[31:0];
         end
         2'b10: begin
            if (mb == 32'd0) begin
               elo = 32'hFFFF_FFFF; ehi = ma; edz = 1'b1;
            end else begin
               elo = ma / mb; ehi = ma % mb;
            end
         end
         default: begin
            if (mb == 32'd0) begin
               elo = 32'hFFFF_FFFF; ehi = ma; edz = 1'b1;
            end else if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) begin
               elo = ma; ehi = 32'd0;
            end else begin
               elo = 32'(sa / sb); ehi = 32'(sa % sb);
            end
         end
      endcase
   endfunction

   // Issue one operation from IDLE (or the done cycle) and check it to completion.
   // Leaves the bench in the cycle where done is high. glitch_at >= 0 pulses a
   // second start that many edges into the operation.
   task automatic run_op(input logic [1:0] mop, input logic [W-1:0] ma,
                         input logic [W-1:0] mb, input int glitch_at, input string tag);
      logic [W-1:0] ehi;
      logic [W-1:0] elo;
      logic         edz;
      int           n;
      model(mop, ma, mb, ehi, elo, edz);
      start = 1'b1; op = mop; a = ma; b = mb;
      tick();
      start = 1'b0; op = 2'($urandom_range(0, 3)); a = $urandom(); b = $urandom();
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      chk({tag, "_done_low"}, 64'(done), 64'd0);
      n = 0;
      while (done !== 1'b1 && n < 100) begin
         if (n == glitch_at) begin
            start = 1'b1; op = 2'($urandom_range(0, 3)); a = $urandom(); b = $urandom();
         end else begin
            start = 1'b0;
         end
         tick();
         n++;
         if (n == 5) begin
            chk({tag, "_hold_hi"}, 64'(hi), 64'(prev_hi));
            chk({tag, "_hold_lo"}, 64'(lo), 64'(prev_lo));
         end
      end
      start = 1'b0;
      chk({tag, "_latency"}, 64'(n), 64'(W + 1));
      chk({tag, "_hi"}, 64'(hi), 64'(ehi));
      chk({tag, "_lo"}, 64'(lo), 64'(elo));
`ifdef MULDIV_DIVZERO_EN
      chk({tag, "_dz"}, 64'(dz), 64'(edz));
`endif
      prev_hi = ehi;
      prev_lo = elo;
   endtask

   // After a completion: done must drop and the result must persist
   task automatic idle_after(input string tag);
      tick();
      chk({tag, "_done_pulse"}, 64'(done), 64'd0);
      chk({tag, "_busy_idle"}, 64'(busy), 64'd0);
      chk({tag, "_keep_hi"}, 64'(hi), 64'(prev_hi));
      chk({tag, "_keep_lo"}, 64'(lo), 64'(prev_lo));
   endtask

   initial begin
      int          seen_done;
      logic [1:0]  rop;
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      reset = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
      prev_hi = '0; prev_lo = '0;

      // reset state
      tick(); tick();
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_hi", 64'(hi), 64'd0);
      chk("rst_lo", 64'(lo), 64'd0);
`ifdef MULDIV_DIVZERO_EN
      chk("rst_dz", 64'(dz), 64'd0);
`endif
      reset = 1'b1;
      tick();

      // directed cases
      run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, "multu_max"); idle_after("multu_max");
      run_op(2'b01, 32'hFFFF_FFFD, 32'd7, -1, "mult_neg");          idle_after("mult_neg");
      run_op(2'b01, 32'h8000_0000, 32'h8000_0000, -1, "mult_min");  idle_after("mult_min");
      run_op(2'b11, 32'hFFFF_FFF9, 32'd2, -1, "div_neg");           idle_after("div_neg");
      run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, -1, "div_ovf");   idle_after("div_ovf");
      run_op(2'b10, 32'd100, 32'd0, -1, "divu_zero");               idle_after("divu_zero");
      run_op(2'b11, 32'hFFFF_FFF9, 32'd0, -1, "div_zero_neg");      idle_after("div_zero_neg");
      run_op(2'b10, 32'hFFFF_FFFF, 32'd3, -1, "divu_big");          idle_after("divu_big");

      // start pulsed mid-CALC is ignored
      run_op(2'b00, 32'd12345, 32'd6789, 10, "glitch");             idle_after("glitch");

      // back-to-back: the second start is issued in the done cycle
      run_op(2'b01, 32'hFFFF_0000, 32'h0001_0000, -1, "b2b_first");
      run_op(2'b11, 32'd1000, 32'hFFFF_FFF9, -1, "b2b_second");
      idle_after("b2b_second");

      // abort at CALC iteration 10, start held while reset is low
      start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd5;
      tick();
      start = 1'b0;
      repeat (10) tick();
      reset = 1'b0; start = 1'b1;
      tick();
      reset = 1'b1; start = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_hi", 64'(hi), 64'd0);
      chk("abort_lo", 64'(lo), 64'd0);
      tick();
      chk("abort_idle", 64'(busy), 64'd0);
      seen_done = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done === 1'b1) seen_done++;
      end
      chk("abort_no_done", 64'(seen_done), 64'd0);
      prev_hi = '0; prev_lo = '0;

      // randomized run, mixing back-to-back and idle gaps plus corner operands
      for (int i = 0; i < 50; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom();
         rb  = $urandom();
         case ($urandom_range(0, 5))
            0:       rb = 32'd0;
            1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2:       rb = 32'($urandom_range(1, 255));
            default: rb = rb;
         endcase
         run_op(rop, ra, rb, -1, "rand");
         if ($urandom_range(0, 1) == 0) begin
            idle_after("rand");
         end
      end
      idle_after("final");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
